// File: rtl/uart_rx_sniffer.sv
// UART receive monitor: synchronises a serial line, deframes characters and
// queues {ferr, perr, data} in a first-word-fall-through FIFO with status counters.
module uart_rx_sniffer #(
    parameter int         CLK_HZ     = 100_000_000,
    parameter int         BAUD       = 19200,
    parameter int         DATA_BITS  = 8,
    parameter int         PARITY     = 0,
    parameter int         STOP_BITS  = 1,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] EOT_CHAR   = 8'h04
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        rx,
    input  logic                        out_ready,
    input  logic                        clr_sticky,
    output logic                        out_valid,
    output logic [DATA_BITS-1:0]        out_data,
    output logic                        out_perr,
    output logic                        out_ferr,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overrun,
    output logic                        eot,
    output logic                        busy,
    output logic [15:0]                 char_count,
    output logic [7:0]                  glitch_count
);
    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int TW       = $clog2(BIT_CYC + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int EW       = DATA_BITS + 2;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_STOP2} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [TW-1:0]        timer_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q, ferr_q;

    logic                 rx_s, start_edge, tick, last_bit;
    logic                 load_half, glitch, sample_data, sample_par, sample_stop, push;
    logic                 ferr_now, eot_match, pop, full, accept;
    logic [8:0]           data_ext;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 overrun_q, eot_q;
    logic [15:0]          char_count_q;
    logic [7:0]           glitch_count_q;

    // Synchroniser and edge history idle high so reset never looks like a start edge.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rx_s       = sync2_q;
    assign start_edge = prev_q & ~sync2_q;
    assign tick       = (timer_q == TW'(1));
    assign last_bit   = (bit_cnt_q == 4'(DATA_BITS - 1));

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_edge) state_d = S_START;
            S_START: if (tick) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (tick && last_bit) state_d = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (tick) state_d = S_STOP;
            S_STOP:  if (tick) state_d = (STOP_BITS == 2) ? S_STOP2 : S_IDLE;
            S_STOP2: if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_half   = 1'b0;
        glitch      = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            S_IDLE:  load_half   = start_edge;
            S_START: glitch      = tick & rx_s;
            S_DATA:  sample_data = tick;
            S_PAR:   sample_par  = tick;
            S_STOP: begin
                sample_stop = tick;
                push        = tick & (STOP_BITS == 1);
            end
            S_STOP2: begin
                sample_stop = tick;
                push        = tick;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (load_half)           timer_q <= TW'(HALF_CYC);
            else if (tick)           timer_q <= TW'(BIT_CYC);
            else if (timer_q != '0)  timer_q <= timer_q - TW'(1);

            if (load_half) begin
                bit_cnt_q <= '0;
                perr_q    <= 1'b0;
                ferr_q    <= 1'b0;
            end
            if (sample_data) begin
                shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (sample_par)          perr_q <= ((^shift_q) ^ rx_s) != (PARITY == 1);
            if (sample_stop && !rx_s) ferr_q <= 1'b1;
        end
    end

    // The final stop sample feeds the pushed entry directly, so fold it in here.
    assign ferr_now  = ferr_q | ~rx_s;
    assign data_ext  = 9'(shift_q);
    assign eot_match = ((data_ext ^ {1'b0, EOT_CHAR}) & 9'h0FF) == 9'h000;

    assign level  = wr_ptr_q - rd_ptr_q;
    assign full   = (level == LVL_FULL);
    assign pop    = out_valid & out_ready;
    assign accept = push & (~full | pop);

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (accept) mem_q[wr_ptr_q[AW-1:0]] <= {ferr_now, perr_q, shift_q};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            overrun_q      <= 1'b0;
            eot_q          <= 1'b0;
            char_count_q   <= '0;
            glitch_count_q <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + (AW+1)'(1);

            if (push && !accept) overrun_q <= 1'b1;
            else if (clr_sticky) overrun_q <= 1'b0;

            eot_q <= accept & eot_match & ~perr_q & ~ferr_now;

            if (accept && char_count_q != 16'hFFFF)  char_count_q   <= char_count_q + 16'd1;
            if (glitch && glitch_count_q != 8'hFF)   glitch_count_q <= glitch_count_q + 8'd1;
        end
    end

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid    = (level != '0);
    assign out_data     = out_valid ? head[DATA_BITS-1:0] : '0;
    assign out_perr     = out_valid & head[DATA_BITS];
    assign out_ferr     = out_valid & head[DATA_BITS+1];
    assign overrun      = overrun_q;
    assign eot          = eot_q;
    assign busy         = (state_q != S_IDLE);
    assign char_count   = char_count_q;
    assign glitch_count = glitch_count_q;

endmodule
